// File: rtl/mdu_unit.sv
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               mult/multu/div/divu latch their operands, stay busy for a
//               fixed number of cycles, then write HI/LO in one go.
//               mthi/mtlo write HI/LO immediately, and mfhi/mflo are read
//               back combinationally through rdata.
//               Optional feature macro: MDU_MADD_EN enables
//               madd/maddu/msub/msubu (ops 9-12) as accumulate operations.
// Ports       : clk, reset_n (async, active-low)
//               start, op[3:0], a[31:0], b[31:0]  - E-stage MD request
//               busy, tnew[3:0]                    - stall controller
//               hi[31:0], lo[31:0], rdata[31:0]    - architectural results
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [3:0]  tnew,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mfhi  = 4'd5;
  localparam logic [3:0] c_op_mflo  = 4'd6;
  localparam logic [3:0] c_op_mthi  = 4'd7;
  localparam logic [3:0] c_op_mtlo  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_op_madd  = 4'd9;
  localparam logic [3:0] c_op_maddu = 4'd10;
  localparam logic [3:0] c_op_msub  = 4'd11;
  localparam logic [3:0] c_op_msubu = 4'd12;
`endif

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic       w_is_div_req;
  logic       w_is_long_req;
  logic [3:0] w_load_cnt;

  always_comb begin
    w_is_div_req  = (op == c_op_div) || (op == c_op_divu);
    w_is_long_req = (op == c_op_mult) || (op == c_op_multu) || w_is_div_req;
`ifdef MDU_MADD_EN
    if ((op == c_op_madd) || (op == c_op_maddu) ||
        (op == c_op_msub) || (op == c_op_msubu)) begin
      w_is_long_req = 1'b1;
    end
`endif
    w_load_cnt = w_is_div_req ? c_div_cnt : c_mult_cnt;
  end

  // --------------------------------------------------------------------------
  // Datapath, evaluated from the latched operands
  // --------------------------------------------------------------------------
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  // The low 64 bits of a product of sign-extended operands equal the signed
  // 64-bit product, so no signed arithmetic types are needed.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed division runs on magnitudes and fixes signs afterwards; this keeps
  // 0x80000000 / -1 well defined (magnitude 2^31 wraps back to 0x80000000).
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_dvs_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_by_zero;

  assign w_div_signed  = (r_op == c_op_div);
  assign w_a_neg       = w_div_signed & r_a[31];
  assign w_b_neg       = w_div_signed & r_b[31];
  assign w_dvd         = w_a_neg ? (-r_a) : r_a;
  assign w_dvs         = w_b_neg ? (-r_b) : r_b;
  assign w_dvs_safe    = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
  assign w_q_mag       = w_dvd / w_dvs_safe;
  assign w_r_mag       = w_dvd % w_dvs_safe;
  assign w_quo         = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
  assign w_rem         = w_a_neg ? (-w_r_mag) : w_r_mag;
  assign w_div_by_zero = ((r_op == c_op_div) || (r_op == c_op_divu)) && (r_b == 32'd0);

  logic [63:0] w_res;

  always_comb begin
    w_res = {r_hi, r_lo};
    case (r_op)
      c_op_mult:  w_res = w_prod_s;
      c_op_multu: w_res = w_prod_u;
      c_op_div:   w_res = {w_rem, w_quo};
      c_op_divu:  w_res = {w_rem, w_quo};
`ifdef MDU_MADD_EN
      c_op_madd:  w_res = {r_hi, r_lo} + w_prod_s;
      c_op_maddu: w_res = {r_hi, r_lo} + w_prod_u;
      c_op_msub:  w_res = {r_hi, r_lo} - w_prod_s;
      c_op_msubu: w_res = {r_hi, r_lo} - w_prod_u;
`endif
      default:    w_res = {r_hi, r_lo};
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM and architectural registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_long_req) begin
              r_op    <= op;
              r_a     <= a;
              r_b     <= b;
              r_cnt   <= w_load_cnt;
              r_state <= S_RUN;
            end else if (op == c_op_mthi) begin
              r_hi <= a;
            end else if (op == c_op_mtlo) begin
              r_lo <= a;
            end
          end
        end
        S_RUN: begin
          // Requests arriving while busy are dropped on purpose.
          if (r_cnt == 4'd1) begin
            if (!w_div_by_zero) begin
              r_hi <= w_res[63:32];
              r_lo <= w_res[31:0];
            end
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign tnew = (r_state == S_RUN) ? r_cnt : 4'd0;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    case (op)
      c_op_mfhi: rdata = r_hi;
      c_op_mflo: rdata = r_lo;
      default:   rdata = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  qualifies op in the current cycle (E-stage MD instruction valid).
REQ-006 SHALL have port op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; other codes are ignored.
REQ-007 SHALL have port a  input  32  rs operand.
REQ-008 SHALL have port b  input  32  rt operand.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; drives the stall controller.
REQ-010 SHALL have port tnew  output  4  cycles remaining until HI/LO are valid; 0 when idle.
REQ-011 SHALL have port hi  output  32  architectural HI register.
REQ-012 SHALL have port lo  output  32  architectural LO register.
REQ-013 SHALL have port rdata  output  32  combinational result: hi for op 5, lo for op 6, else 0.

Function
REQ-014 SHALL implement FSM states IDLE and RUN with a 4-bit down-counter.
REQ-015 SHALL, in IDLE with start=1 and op in {1,2,3,4}, latch a, b and op at the edge, enter RUN, and load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
REQ-016 SHALL drive busy=1 and tnew=counter in RUN; busy=0 and tnew=0 in IDLE.
REQ-017 SHALL decrement the counter each cycle in RUN; on the edge where the counter is 1, write HI/LO and return to IDLE, so busy is high for exactly N cycles after the start edge.
REQ-018 SHALL compute mult as the signed 64-bit product and multu as the unsigned product; HI gets bits 63:32, LO gets bits 31:0.
REQ-019 SHALL compute div as LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign; divu as an unsigned quotient and remainder.
REQ-020 SHALL, for div with a=0x80000000 and b=0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-021 SHALL, when b=0 for div/divu, still run DIV_CYCLES cycles and leave HI/LO unchanged.
REQ-022 SHALL, in IDLE with start=1, write a to HI for mthi and a to LO for mtlo at that edge, with no busy cycles.
REQ-023 SHALL ignore start (no state or register change) while busy=1; the stall controller guarantees this does not occur legally.
REQ-024 SHALL keep HI/LO stable during RUN; rdata in RUN returns the pre-operation values.
REQ-025 SHALL treat op 0 and undefined codes as no-ops.

Reset
REQ-026 SHALL, while reset_n=0 at any time including mid-RUN, force IDLE, counter=0, hi=0, lo=0, busy=0 and tnew=0, and discard the in-flight operation.
REQ-027 SHALL resume normal operation at the first rising clk edge after reset_n deasserts.

Configuration
REQ-028 SHALL, with macro MDU_MADD_EN defined, accept ops 9-12 as MULT_CYCLES operations that write {HI,LO} = {HI,LO} +/- the signed (9,11) or unsigned (10,12) product, modulo 2^64.
REQ-029 SHALL, without MDU_MADD_EN, treat ops 9-12 as no-ops per REQ-025.

Verification
REQ-030 SHALL cover: mult a=0xFFFFFFFE, b=3 -> busy high 5 cycles, tnew 5,4,3,2,1; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 SHALL cover: div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with b=0 -> hi/lo unchanged after 10 cycles.
REQ-032 SHALL cover: mthi a=0x12345678, then mfhi the next cycle -> rdata=0x12345678, busy never asserted.
REQ-033 SHALL cover: multu a=b=0xFFFFFFFF, then reset_n low in the 3rd busy cycle -> busy=0, hi=lo=0 immediately; a subsequent mult 2*3 -> lo=6.
REQ-034 SHALL cover: start with mtlo while busy -> lo unchanged, and completion matches the original operation.
REQ-035 SHALL cover, with MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu a=1, b=1 -> hi=1, lo=0; without the macro -> no change.
